pipe_stage_reg: RTL

- Parametrised fetch/decode-style pipeline stage register.
- Replaces fixed 32-bit stall-only stage regs with a valid/ready stage that has a 2-entry skid buffer, a flush input, and bubble (NOP) injection.
- Sits between any two core pipeline stages (IF/ID first); carries PC, instruction word and memory ACK.
- Full throughput (1 transfer/cycle); in_ready is fully registered, breaking the backpressure combinational path.

---
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, flush and bubble injection.
// Optional stall/flush performance counters are enabled by defining STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
    parameter int unsigned         PC_W        = 32,
    parameter int unsigned         DATA_W      = 32,
    parameter logic [DATA_W-1:0]   BUBBLE_INST = DATA_W'(32'h0000_0013),
    parameter int unsigned         CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_inst,
    input  logic              in_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              out_ack,
    input  logic              stall,
    input  logic              flush
`ifdef STAGE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              m_valid_q, m_valid_d;
    logic [PC_W-1:0]   m_pc_q, m_pc_d;
    logic [DATA_W-1:0] m_inst_q, m_inst_d;
    logic              m_ack_q, m_ack_d;

    logic              s_valid_q, s_valid_d;
    logic [PC_W-1:0]   s_pc_q, s_pc_d;
    logic [DATA_W-1:0] s_inst_q, s_inst_d;
    logic              s_ack_q, s_ack_d;

    logic acc;
    logic drn;

    // in_ready depends only on reset and a register, so no backpressure path from out_ready.
    assign in_ready  = reset & ~s_valid_q;
    assign acc       = in_valid & in_ready;
    assign drn       = m_valid_q & out_ready & ~stall;

    assign out_valid = m_valid_q;
    assign out_pc    = m_pc_q;
    assign out_inst  = m_valid_q ? m_inst_q : BUBBLE_INST;
    assign out_ack   = m_valid_q & m_ack_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_pc_d    = m_pc_q;
        m_inst_d  = m_inst_q;
        m_ack_d   = m_ack_q;
        s_valid_d = s_valid_q;
        s_pc_d    = s_pc_q;
        s_inst_d  = s_inst_q;
        s_ack_d   = s_ack_q;

        if (!reset) begin
            m_valid_d = 1'b0;
            m_pc_d    = '0;
            m_inst_d  = '0;
            m_ack_d   = 1'b0;
            s_valid_d = 1'b0;
            s_pc_d    = '0;
            s_inst_d  = '0;
            s_ack_d   = 1'b0;
        end else if (flush) begin
            // Payload registers keep their contents; only the valid bits are killed.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || drn) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_pc_d    = s_pc_q;
                m_inst_d  = s_inst_q;
                m_ack_d   = s_ack_q;
                s_valid_d = 1'b0;
            end else if (acc) begin
                m_valid_d = 1'b1;
                m_pc_d    = in_pc;
                m_inst_d  = in_inst;
                m_ack_d   = in_ack;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (acc) begin
            s_valid_d = 1'b1;
            s_pc_d    = in_pc;
            s_inst_d  = in_inst;
            s_ack_d   = in_ack;
        end
    end

    always_ff @(posedge clk) begin
        m_valid_q <= m_valid_d;
        m_pc_q    <= m_pc_d;
        m_inst_q  <= m_inst_d;
        m_ack_q   <= m_ack_d;
        s_valid_q <= s_valid_d;
        s_pc_q    <= s_pc_d;
        s_inst_q  <= s_inst_d;
        s_ack_q   <= s_ack_d;
    end

`ifdef STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!reset) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (m_valid_q && !(out_ready && !stall) && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
